cla64_addsub_pipe: RTL and testbench

- Pipelined 64-bit add/subtract unit built from carry-lookahead slices.
- Each pipeline stage resolves one slice and registers the carry into the next stage.
- Valid/ready handshake on both sides; sits between operand-issue logic and the result consumer.
- Provides subtraction (the inverse of the 64-bit CLA adder) plus streaming and backpressure.

---
 rtl/cla64_addsub_pipe.sv | 154 +++++++++++++++
 tb/tb_cla64_addsub_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla64_addsub_pipe.sv
// Pipelined add/subtract unit: one carry-lookahead slice is resolved per stage, with a
// global stall. Defining OVERFLOW_FLAG_EN adds the out_ovf signed-overflow output.
module cla64_addsub_pipe #(
   parameter int WIDTH   = 64,
   parameter int SLICE_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_zero
`ifdef OVERFLOW_FLAG_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int STAGES = WIDTH / SLICE_W;
   localparam int LAST   = STAGES - 1;

   // Lookahead over one slice. Each carry is formed as the flat sum of generate terms.
   // Returns {carry_out, sum}.
   function automatic logic [SLICE_W:0] cla_slice(input logic [SLICE_W-1:0] a,
                                                  input logic [SLICE_W-1:0] b,
                                                  input logic               c0);
      logic [SLICE_W-1:0] g;
      logic [SLICE_W-1:0] p;
      logic [SLICE_W:0]   c;
      logic               acc_g;
      logic               acc_p;
      g    = a & b;
      p    = a ^ b;
      c    = {(SLICE_W+1){1'b0}};
      c[0] = c0;
      for (int i = 1; i <= SLICE_W; i++) begin
         acc_g = 1'b0;
         acc_p = 1'b1;
         for (int j = i - 1; j >= 0; j--) begin
            acc_g = acc_g | (acc_p & g[j]);
            acc_p = acc_p & p[j];
         end
         c[i] = acc_g | (acc_p & c0);
      end
      return {c[SLICE_W], p ^ c[SLICE_W-1:0]};
   endfunction

   logic [STAGES-1:0] valid_r;
   logic [STAGES-1:0] carry_r;
   logic [STAGES-1:0] carry_nx_s;
   logic [STAGES-1:0] c_src_s;
   logic [WIDTH-1:0]  a_r       [STAGES-1];
   logic [WIDTH-1:0]  b_r       [STAGES-1];
   logic [WIDTH-1:0]  sum_r     [STAGES];
   logic [WIDTH-1:0]  a_src_s   [STAGES];
   logic [WIDTH-1:0]  b_src_s   [STAGES];
   logic [WIDTH-1:0]  sum_src_s [STAGES];
   logic [WIDTH-1:0]  sum_nx_s  [STAGES];
   logic [SLICE_W:0]  slice_s   [STAGES];
   logic              zero_r;
   logic              adv_s;
`ifdef OVERFLOW_FLAG_EN
   logic              ovf_r;
`endif

   assign adv_s     = !valid_r[LAST] || out_ready;
   assign in_ready  = adv_s;
   assign out_valid = valid_r[LAST];
   assign out_sum   = sum_r[LAST];
   assign out_cout  = carry_r[LAST];
   assign out_zero  = zero_r;
`ifdef OVERFLOW_FLAG_EN
   assign out_ovf   = ovf_r;
`endif

   // Stage operand sources. Operands are zeroed for bubbles so unknown input data never enters the pipe.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         a_src_s[k]   = {WIDTH{1'b0}};
         b_src_s[k]   = {WIDTH{1'b0}};
         sum_src_s[k] = {WIDTH{1'b0}};
         c_src_s[k]   = 1'b0;
      end
      if (in_valid) begin
         a_src_s[0] = in_a;
         b_src_s[0] = in_sub ? ~in_b : in_b;
         c_src_s[0] = in_sub ^ in_cin;
      end else begin
         a_src_s[0] = {WIDTH{1'b0}};
         b_src_s[0] = {WIDTH{1'b0}};
         c_src_s[0] = 1'b0;
      end
      for (int k = 1; k < STAGES; k++) begin
         a_src_s[k]   = a_r[k-1];
         b_src_s[k]   = b_r[k-1];
         sum_src_s[k] = sum_r[k-1];
         c_src_s[k]   = carry_r[k-1];
      end
   end

   // Per-stage slice resolution: stage k fills in its own slice of the travelling sum.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         slice_s[k]  = cla_slice(a_src_s[k][k*SLICE_W +: SLICE_W],
                                 b_src_s[k][k*SLICE_W +: SLICE_W], c_src_s[k]);
         sum_nx_s[k] = sum_src_s[k];
         sum_nx_s[k][k*SLICE_W +: SLICE_W] = slice_s[k][SLICE_W-1:0];
         carry_nx_s[k] = slice_s[k][SLICE_W];
      end
   end

   // Pipeline registers: every stage advances together or every stage holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= {STAGES{1'b0}};
         carry_r <= {STAGES{1'b0}};
         for (int k = 0; k < STAGES; k++) begin
            sum_r[k] <= {WIDTH{1'b0}};
         end
         for (int k = 0; k < LAST; k++) begin
            a_r[k] <= {WIDTH{1'b0}};
            b_r[k] <= {WIDTH{1'b0}};
         end
         zero_r <= 1'b1;
`ifdef OVERFLOW_FLAG_EN
         ovf_r  <= 1'b0;
`endif
      end else if (adv_s) begin
         valid_r <= {valid_r[STAGES-2:0], in_valid};
         carry_r <= carry_nx_s;
         for (int k = 0; k < STAGES; k++) begin
            sum_r[k] <= sum_nx_s[k];
         end
         for (int k = 0; k < LAST; k++) begin
            a_r[k] <= a_src_s[k];
            b_r[k] <= b_src_s[k];
         end
         zero_r <= ~|sum_nx_s[LAST];
`ifdef OVERFLOW_FLAG_EN
         // The subtrahend is already inverted here, so one rule covers add and subtract.
         ovf_r  <= (a_src_s[LAST][WIDTH-1] == b_src_s[LAST][WIDTH-1]) &&
                   (sum_nx_s[LAST][WIDTH-1] != a_src_s[LAST][WIDTH-1]);
`endif
      end
   end

endmodule

// File: tb/tb_cla64_addsub_pipe.sv
// Self-checking bench for cla64_addsub_pipe: directed vectors, bubbles, backpressure,
// randomized streaming against an arithmetic scoreboard, and reset with beats in flight.
module tb_cla64_addsub_pipe;

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        zero;
      logic        ovf;
   } exp_t;

   localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
   localparam logic signed [65:0] SMIN = 66'sh3_8000_0000_0000_0000;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        in_sub;
   logic        in_cin;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_sum;
   logic        out_cout;
   logic        out_zero;
`ifdef OVERFLOW_FLAG_EN
   logic        out_ovf;
`endif

   int          n_tests;
   int          n_fail;
   exp_t        exp_q[$];
   exp_t        mon_e;
   logic        hold_pend;
   logic [63:0] hold_sum;

   cla64_addsub_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_zero  (out_zero)
`ifdef OVERFLOW_FLAG_EN
      ,
      .out_ovf   (out_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference result straight from the arithmetic definition.
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                  input logic sub, input logic cin);
      exp_t               e;
      logic [64:0]        r;
      logic signed [65:0] s;
      if (sub) begin
         r      = {1'b0, a} - {1'b0, b} - {64'd0, cin};
         e.cout = ~r[64];
         s      = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed({65'd0, cin});
      end else begin
         r      = {1'b0, a} + {1'b0, b} + {64'd0, cin};
         e.cout = r[64];
         s      = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}) + $signed({65'd0, cin});
      end
      e.sum  = r[63:0];
      e.zero = (r[63:0] == 64'd0);
      e.ovf  = (s > SMAX) || (s < SMIN);
      return e;
   endfunction

   // Scoreboard, output-hold checker and accept recorder, all sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check_val("hold_valid", {63'd0, out_valid}, 64'd1);
            check_val("hold_sum", out_sum, hold_sum);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_val("spurious_out", {63'd0, out_valid}, 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check_val("sb_sum", out_sum, mon_e.sum);
               check_val("sb_cout", {63'd0, out_cout}, {63'd0, mon_e.cout});
               check_val("sb_zero", {63'd0, out_zero}, {63'd0, mon_e.zero});
`ifdef OVERFLOW_FLAG_EN
               check_val("sb_ovf", {63'd0, out_ovf}, {63'd0, mon_e.ovf});
`endif
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_sub, in_cin));
         hold_pend = out_valid && !out_ready;
         hold_sum  = out_sum;
      end
   end

   // One beat into an empty pipe; checks latency and the spec-given result.
   task automatic directed(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic sub, input logic cin, input logic [63:0] exp_sum,
                           input logic exp_cout, input logic exp_zero, input logic exp_ovf);
      int lat;
      out_ready = 1'b1;
      in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = 64'hx; in_b = 64'hx;
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check_val({tag, "_lat"}, 64'(lat), 64'd4);
      check_val({tag, "_sum"}, out_sum, exp_sum);
      check_val({tag, "_cout"}, {63'd0, out_cout}, {63'd0, exp_cout});
      check_val({tag, "_zero"}, {63'd0, out_zero}, {63'd0, exp_zero});
`ifdef OVERFLOW_FLAG_EN
      check_val({tag, "_ovf"}, {63'd0, out_ovf}, {63'd0, exp_ovf});
`endif
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] pat;
      logic       obs [12];
      int         i;
      int         stall;
      int         guard;
      int         seen;
      logic       acc;
      logic       rel;

      n_tests = 0; n_fail = 0;
      hold_pend = 1'b0; hold_sum = 64'd0;
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_a = 64'd0; in_b = 64'd0; in_sub = 1'b0; in_cin = 1'b0;
      #2 rst_n = 1'b0;
      #10;
      check_val("rst_valid", {63'd0, out_valid}, 64'd0);
      check_val("rst_sum", out_sum, 64'd0);
      check_val("rst_cout", {63'd0, out_cout}, 64'd0);
      check_val("rst_zero", {63'd0, out_zero}, 64'd1);
      check_val("rst_ready", {63'd0, in_ready}, 64'd1);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      directed("add", 64'h1234567890000000, 64'h00AABBCCDDEEFF11, 1'b0, 1'b0,
               64'h12DF12456DEEFF11, 1'b0, 1'b0, 1'b0);
      directed("sub", 64'h5233458, 64'h4578213, 1'b1, 1'b0, 64'h0CBB245, 1'b1, 1'b0, 1'b0);
      directed("subswap", 64'h4578213, 64'h5233458, 1'b1, 1'b0,
               64'hFFFFFFFFFF344DBB, 1'b0, 1'b0, 1'b0);
      directed("ripple", 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b1, 1'b0);
      directed("ovf", 64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b0, 1'b0,
               64'h8000000000000000, 1'b0, 1'b0, 1'b1);
      directed("subborrow", 64'd5, 64'd5, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b0);

      // Bubbles: out_valid must replay the input valid pattern four cycles later.
      pat = 4'b0101;
      out_ready = 1'b1;
      for (int j = 0; j < 12; j++) begin
         in_valid = (j < 4) ? pat[j] : 1'b0;
         in_a = 64'(j); in_b = 64'(3 * j); in_sub = 1'b0; in_cin = 1'b0;
         @(negedge clk);
         obs[j] = out_valid;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         check_val("bubble_valid", {63'd0, obs[j+4]}, {63'd0, pat[j]});
      end
      check_val("bubble_lead", {63'd0, obs[3]}, 64'd0);

      // Backpressure: six beats with the consumer stalled, then released.
      out_ready = 1'b0;
      i = 1; stall = 0; guard = 0; rel = 1'b0;
      while (i <= 6 && guard < 100) begin
         in_valid = 1'b1; in_a = 64'(i); in_b = 64'(i); in_sub = 1'b0; in_cin = 1'b0;
         @(negedge clk);
         acc = in_ready;
         if (!acc) begin
            if (stall == 0) check_val("bp_ready_low", 64'(i), 64'd5);
            stall++;
            check_val("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check_val("bp_sum", out_sum, 64'd2);
            if (stall == 3) rel = 1'b1;
         end
         @(posedge clk); #1;
         if (rel) out_ready = 1'b1;
         if (acc) i++;
         guard++;
      end
      in_valid = 1'b0;
      check_val("bp_guard", 64'(i), 64'd7);
      check_val("bp_stalls", 64'(stall), 64'd3);
      repeat (10) begin @(posedge clk); #1; end
      check_val("bp_drain", 64'(exp_q.size()), 64'd0);

      // Randomized streaming with random backpressure.
      for (int j = 0; j < 300; j++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_a      = {$urandom, $urandom};
         in_b      = ($urandom_range(0, 7) == 0) ? ~in_a : {$urandom, $urandom};
         in_sub    = 1'($urandom_range(0, 1));
         in_cin    = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (10) begin @(posedge clk); #1; end
      check_val("rand_drain", 64'(exp_q.size()), 64'd0);

      // Reset with beats in flight: nothing may survive it.
      out_ready = 1'b0;
      for (int j = 0; j < 4; j++) begin
         in_valid = 1'b1; in_a = 64'(100 + j); in_b = 64'(7); in_sub = 1'b0; in_cin = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      check_val("mrst_valid", {63'd0, out_valid}, 64'd0);
      check_val("mrst_sum", out_sum, 64'd0);
      check_val("mrst_zero", {63'd0, out_zero}, 64'd1);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check_val("mrst_ready", {63'd0, in_ready}, 64'd1);
      seen = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check_val("mrst_stale", 64'(seen), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
